// File: rtl/l1_buf_capture_sequencer.sv
// L1-triggered capture sequencer: waits for a masked beam trigger, streams len+1
// beats of one ADC channel over AXI4-Stream, then holds off before re-arming.
module l1_buf_capture_sequencer #(
  parameter int NBEAMS  = 2,
  parameter int NCHAN   = 8,
  parameter int HOLDOFF = 256
) (
  input  logic                  aclk,
  input  logic                  reset_i,
  input  logic [NCHAN*128-1:0]  dat_i,
  input  logic [NBEAMS-1:0]     trig_i,
  input  logic                  update_i,
  input  logic [2:0]            cfg_chan_i,
  input  logic [7:0]            cfg_len_i,
  input  logic [NBEAMS-1:0]     cfg_mask_i,
  input  logic                  cfg_autoscan_i,
  input  logic                  cfg_rearm_i,
  input  logic                  arm_i,
  output logic [127:0]          m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  drop_o,
  output logic [NBEAMS-1:0]     trig_beam_o,
  output logic [2:0]            cur_chan_o
);

  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [2:0]          r_chan;
  logic [7:0]          r_len;
  logic [NBEAMS-1:0]   r_mask;
  logic                r_autoscan;
  logic                r_rearm;
  logic                r_pend;
  logic [7:0]          r_bcnt;
  logic [HW-1:0]       r_hcnt;
  logic [127:0]        r_tdata;
  logic                r_drop;
  logic [NBEAMS-1:0]   r_trigBeam;

  logic                w_hit;
  logic                w_lastBeat;
  logic                w_holdDone;
  logic [127:0]        w_chanBeat;

  assign w_hit      = |(trig_i & r_mask);
  assign w_lastBeat = (r_bcnt == r_len);
  assign w_holdDone = (r_hcnt == HW'(HOLDOFF - 1));
  assign w_chanBeat = dat_i[128*int'(r_chan) +: 128];

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (r_state)
      S_IDLE:    if (arm_i) w_next = S_ARMED;
      S_ARMED:   if (w_hit) w_next = S_CAPTURE;
      S_CAPTURE: begin
        m_tvalid = 1'b1;
        m_tlast  = w_lastBeat;
        m_tdata  = r_tdata;
        busy_o   = 1'b1;
        if (w_lastBeat) w_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        busy_o = 1'b1;
        done_o = (r_hcnt == '0);
        if (w_holdDone) w_next = r_rearm ? S_ARMED : S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Config only changes in IDLE; requests made while busy are deferred until then.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      r_chan     <= 3'd0;
      r_len      <= 8'd63;
      r_mask     <= '1;
      r_autoscan <= 1'b0;
      r_rearm    <= 1'b0;
      r_pend     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (update_i || r_pend) begin
        r_chan     <= cfg_chan_i;
        r_len      <= cfg_len_i;
        r_mask     <= cfg_mask_i;
        r_autoscan <= cfg_autoscan_i;
        r_rearm    <= cfg_rearm_i;
      end
      r_pend <= 1'b0;
    end else begin
      if (update_i) r_pend <= 1'b1;
      if (r_state == S_CAPTURE && w_lastBeat && r_autoscan)
        r_chan <= (r_chan == 3'(NCHAN - 1)) ? 3'd0 : r_chan + 3'd1;
    end
  end

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      r_bcnt     <= '0;
      r_hcnt     <= '0;
      r_tdata    <= '0;
      r_drop     <= 1'b0;
      r_trigBeam <= '0;
    end else begin
      r_tdata <= w_chanBeat;
      r_bcnt  <= (r_state == S_CAPTURE && !w_lastBeat) ? r_bcnt + 8'd1 : 8'd0;
      r_hcnt  <= (r_state == S_HOLDOFF && !w_holdDone) ? r_hcnt + HW'(1) : '0;
      // Beats are never stalled; a refused beat is lost and flagged until re-armed from IDLE.
      if (r_state == S_IDLE && arm_i)
        r_drop <= 1'b0;
      else if (r_state == S_CAPTURE && !m_tready)
        r_drop <= 1'b1;
      if (r_state == S_ARMED && w_hit)
        r_trigBeam <= trig_i & r_mask;
    end
  end

  assign drop_o      = r_drop;
  assign trig_beam_o = r_trigBeam;
  assign cur_chan_o  = r_chan;

endmodule

// File: tb/tb_l1_buf_capture_sequencer.sv
// Scoreboard bench for l1_buf_capture_sequencer: directed captures push expected
// beats, a negedge monitor pops and compares every valid beat.
module tb_l1_buf_capture_sequencer;

  logic            aclk;
  logic            reset_i;
  logic [1023:0]   dat_i;
  logic [1:0]      trig_i;
  logic            update_i;
  logic [2:0]      cfg_chan_i;
  logic [7:0]      cfg_len_i;
  logic [1:0]      cfg_mask_i;
  logic            cfg_autoscan_i;
  logic            cfg_rearm_i;
  logic            arm_i;
  logic [127:0]    m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic            busy_o;
  logic            done_o;
  logic            drop_o;
  logic [1:0]      trig_beam_o;
  logic [2:0]      cur_chan_o;

  l1_buf_capture_sequencer #(.NBEAMS(2), .NCHAN(8), .HOLDOFF(256)) dut (
    .aclk(aclk), .reset_i(reset_i), .dat_i(dat_i), .trig_i(trig_i),
    .update_i(update_i), .cfg_chan_i(cfg_chan_i), .cfg_len_i(cfg_len_i),
    .cfg_mask_i(cfg_mask_i), .cfg_autoscan_i(cfg_autoscan_i),
    .cfg_rearm_i(cfg_rearm_i), .arm_i(arm_i), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy_o(busy_o), .done_o(done_o), .drop_o(drop_o),
    .trig_beam_o(trig_beam_o), .cur_chan_o(cur_chan_o)
  );

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t      sbQ[$];
  int         nVectors = 0;
  int         nMiscompare = 0;
  int         cyc = 0;
  int         trigCyc = 0;
  int         doneCyc = 0;
  int         mChan = 0;
  int         mLen = 63;
  logic [1:0] mMask = 2'b11;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [127:0] beatOf(input int c, input int k);
    return {32'hC0DE_0000 + 32'(c), 32'(k), 32'(k * 3 + c), ~32'(k)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    for (int c = 0; c < 8; c++) dat_i[128*c +: 128] = beatOf(c, cyc);
  endtask

  task automatic applyStimulus(input logic upd, input logic arm, input logic [1:0] trig);
    update_i = upd;
    arm_i    = arm;
    trig_i   = trig;
    tick();
    update_i = 1'b0;
    arm_i    = 1'b0;
  endtask

  // Trigger sampled at the end of the current cycle; first beat is this cycle's data.
  task automatic fire(input logic [1:0] trig);
    trigCyc = cyc;
    for (int i = 0; i <= mLen; i++)
      sbQ.push_back('{beatOf(mChan, cyc + i), (i == mLen)});
    trig_i = trig;
    tick();
    trig_i = 2'b00;
    checkOutput("trigBeam", 128'(trig_beam_o), 128'(trig & mMask));
    checkOutput("busyCapture", 128'(busy_o), 128'(1));
  endtask

  task automatic waitDone();
    int n = 0;
    while (done_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("doneCycle", 128'(cyc), 128'(trigCyc + mLen + 2));
    doneCyc = cyc;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("holdoffEnd", 128'(cyc), 128'(doneCyc + 256));
  endtask

  always @(negedge aclk) begin
    if (!reset_i && m_tvalid) begin
      if (sbQ.size() == 0) begin
        nVectors++;
        nMiscompare++;
        $display("[TB] FAIL unexpectedBeat: got beat %0h, expected no beat (cycle %0d)", m_tdata, cyc);
      end else begin
        beat_t e;
        e = sbQ.pop_front();
        checkOutput("beatData", m_tdata, e.data);
        checkOutput("beatLast", 128'(m_tlast), 128'(e.last));
      end
    end
  end

  initial begin
    reset_i = 1'b0; dat_i = '0; trig_i = '0; update_i = 1'b0; arm_i = 1'b0;
    cfg_chan_i = '0; cfg_len_i = '0; cfg_mask_i = '0; cfg_autoscan_i = 1'b0;
    cfg_rearm_i = 1'b0; m_tready = 1'b1;
    #2 reset_i = 1'b1;
    #1;
    checkOutput("rstTvalid", 128'(m_tvalid), 128'(0));
    checkOutput("rstBusy", 128'(busy_o), 128'(0));
    checkOutput("rstDone", 128'(done_o), 128'(0));
    checkOutput("rstDrop", 128'(drop_o), 128'(0));
    checkOutput("rstTrigBeam", 128'(trig_beam_o), 128'(0));
    checkOutput("rstCurChan", 128'(cur_chan_o), 128'(0));
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    // Basic capture: update and arm together, chan 2, len 3
    cfg_chan_i = 3'd2; cfg_len_i = 8'd3; cfg_mask_i = 2'b11;
    cfg_autoscan_i = 1'b0; cfg_rearm_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00);
    mChan = 2; mLen = 3; mMask = 2'b11;
    checkOutput("curChanLoaded", 128'(cur_chan_o), 128'(2));
    checkOutput("armedNotBusy", 128'(busy_o), 128'(0));
    fire(2'b01);
    waitDone();
    tick();
    checkOutput("donePulseWidth", 128'(done_o), 128'(0));
    arm_i = 1'b1; trig_i = 2'b11;
    tick();
    arm_i = 1'b0;
    waitIdle();
    repeat (4) tick();
    checkOutput("idleStaysIdle", 128'(busy_o), 128'(0));
    trig_i = 2'b00;

    // Dropped beat: m_tready low for one capture cycle
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("dropBeforeCap", 128'(drop_o), 128'(0));
    fire(2'b01);
    m_tready = 1'b0;
    tick();
    m_tready = 1'b1;
    checkOutput("dropSet", 128'(drop_o), 128'(1));
    waitDone();
    waitIdle();
    checkOutput("dropSticky", 128'(drop_o), 128'(1));

    // Mask: beam 0 ignored, beam 1 triggers
    cfg_mask_i = 2'b10;
    applyStimulus(1'b1, 1'b1, 2'b00);
    mMask = 2'b10;
    checkOutput("dropClearedOnArm", 128'(drop_o), 128'(0));
    trig_i = 2'b01;
    repeat (4) tick();
    checkOutput("maskedNoCapture", 128'(busy_o), 128'(0));
    trig_i = 2'b00;
    fire(2'b11);
    waitDone();
    waitIdle();

    // Update during capture is deferred to the next IDLE
    applyStimulus(1'b0, 1'b1, 2'b00);
    fire(2'b10);
    cfg_len_i = 8'd0; cfg_mask_i = 2'b11;
    applyStimulus(1'b1, 1'b0, 2'b00);
    waitDone();
    waitIdle();
    mLen = 0; mMask = 2'b11;
    applyStimulus(1'b0, 1'b1, 2'b00);
    fire(2'b01);
    waitDone();
    waitIdle();

    // Autoscan with rearm: channels 7, 0, 1, 2; triggers held through holdoff
    cfg_chan_i = 3'd7; cfg_len_i = 8'd2; cfg_mask_i = 2'b11;
    cfg_autoscan_i = 1'b1; cfg_rearm_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00);
    mChan = 7; mLen = 2; mMask = 2'b11;
    for (int r = 0; r < 4; r++) begin
      fire((r == 0) ? 2'b01 : 2'b11);
      waitDone();
      checkOutput("autoscanChan", 128'(cur_chan_o), 128'((mChan + 1) % 8));
      mChan = (mChan + 1) % 8;
      if (r < 3) trig_i = 2'b11;
      waitIdle();
    end

    // Reset in the second capture beat aborts the capture
    sbQ.push_back('{beatOf(mChan, cyc), 1'b0});
    trig_i = 2'b01;
    tick();
    trig_i = 2'b00;
    tick();
    reset_i = 1'b1;
    #1;
    checkOutput("abortTvalid", 128'(m_tvalid), 128'(0));
    checkOutput("abortTlast", 128'(m_tlast), 128'(0));
    checkOutput("abortBusy", 128'(busy_o), 128'(0));
    checkOutput("abortCurChan", 128'(cur_chan_o), 128'(0));
    checkOutput("abortTrigBeam", 128'(trig_beam_o), 128'(0));
    tick();
    reset_i = 1'b0;
    mChan = 0; mLen = 63; mMask = 2'b11;
    applyStimulus(1'b0, 1'b1, 2'b00);
    fire(2'b10);
    waitDone();
    checkOutput("defaultNoAutoscan", 128'(cur_chan_o), 128'(0));
    waitIdle();
    trig_i = 2'b01;
    repeat (4) tick();
    checkOutput("defaultNoRearm", 128'(busy_o), 128'(0));
    trig_i = 2'b00;
    repeat (2) tick();

    checkOutput("scoreboardEmpty", 128'(sbQ.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompare);
    $finish;
  end

endmodule
